// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single APB master port.
// Optional ACCESS watchdog is built only when APB_ARB_TIMEOUT_EN is defined.
module apb_rr_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    // Handshake: req[i] rises and stays high with stable attributes until the
    // cycle where done[i] pulses; that pulse is the only acknowledgement.
    input  logic [1:0]              req,
    input  logic                    wr0,
    input  logic                    wr1,
    input  logic [ADDR_WIDTH-1:0]   addr0,
    input  logic [ADDR_WIDTH-1:0]   addr1,
    input  logic [DATA_WIDTH-1:0]   wdata0,
    input  logic [DATA_WIDTH-1:0]   wdata1,
    input  logic [DATA_WIDTH/8-1:0] strb0,
    input  logic [DATA_WIDTH/8-1:0] strb1,
    output logic [1:0]              done,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    err,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    ptrnsfr,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr,
    output logic [1:0]              dbg_state
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   last_q, last_d;
    logic                   wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]  strb_q, strb_d;

    logic in_access;
    logic other_req;
    logic timeout_hit;
    logic complete;
    logic grant;
    logic winner;

    assign in_access = (state_q == ACCESS);
    assign other_req = owner_q ? req[0] : req[1];

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ACCESS is only ever entered from SETUP, so clearing there is "clear on entry".
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if (in_access && !pready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit = in_access && !pready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign complete = in_access && (pready || timeout_hit);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        grant   = 1'b0;
        winner  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    grant   = 1'b1;
                    winner  = (req == 2'b11) ? ~last_q : req[1];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // The owner is excluded here, so only the other requester can win.
                if (complete) begin
                    if (other_req) begin
                        grant   = 1'b1;
                        winner  = ~owner_q;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant) begin
            owner_d = winner;
            last_d  = winner;
            wr_d    = winner ? wr1    : wr0;
            addr_d  = winner ? addr1  : addr0;
            wdata_d = winner ? wdata1 : wdata0;
            strb_d  = winner ? strb1  : strb0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
        end
    end

    // Attribute registers keep their last values in IDLE, so the bus is gated by psel.
    always_comb begin
        psel    = (state_q != IDLE);
        penable = in_access;
        pwrite  = psel ? wr_q    : 1'b0;
        paddr   = psel ? addr_q  : '0;
        pwdata  = psel ? wdata_q : '0;
        pstrb   = psel ? strb_q  : '0;
        ptrnsfr = complete && other_req;
        done    = 2'b00;
        rdata   = '0;
        err     = 1'b0;
        if (complete) begin
            done  = owner_q ? 2'b10 : 2'b01;
            rdata = timeout_hit ? '0 : prdata;
            err   = timeout_hit || pslverr;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever done is nonzero.
`timescale 1ns/1ps
module tb_apb_rr_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int RESP_W = 2 + DW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic          wr0, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [SW-1:0] strb0, strb1;
    logic [1:0]    done;
    logic [DW-1:0] rdata;
    logic          err;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic          ptrnsfr;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic [1:0]    dbg_state;

    logic [RESP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;

    // Slave model: pready after wait_n stalled ACCESS cycles.
    logic [DW-1:0] rd_val  = '0;
    logic          slv_err = 1'b0;
    int            wait_n  = 0;
    int            acc_cnt = 0;

    assign pready  = psel && penable && (acc_cnt >= wait_n);
    assign prdata  = (psel && penable) ? rd_val : '0;
    assign pslverr = psel && penable && slv_err;

    always @(posedge clk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always #5 clk = ~clk;

    apb_rr_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .wr0(wr0), .wr1(wr1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .strb0(strb0), .strb1(strb1),
        .done(done), .rdata(rdata), .err(err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .ptrnsfr(ptrnsfr),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .dbg_state(dbg_state)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] d, input logic [DW-1:0] rd, input logic e);
        exp_q.push_back({d, rd, e});
    endtask

    // Monitor: every done pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en && done !== 2'b00) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=%b rdata=0x%0h err=%b, expected no completion",
                         done, rdata, err);
            end else begin
                chk("completion", {done, rdata, err}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        wr0 = 1'b0; wr1 = 1'b0; addr0 = '0; addr1 = '0;
        wdata0 = '0; wdata1 = '0; strb0 = '0; strb1 = '0;

        // Reset state
        do_reset;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_ctrl", {psel, penable, pwrite, ptrnsfr, done, err}, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pstrb", pstrb, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_state", dbg_state, 0);

        // Single write, minimum latency
        next_cycle;
        wr0 = 1'b1; addr0 = 32'h4; wdata0 = 32'hDEADBEEF; strb0 = 4'hF;
        wait_n = 0; rd_val = 32'h0000A5A5; slv_err = 1'b0;
        push_exp(2'b01, 32'h0000A5A5, 1'b0);
        req = 2'b01;
        @(negedge clk);
        chk("t1_c0_psel", psel, 0);
        next_cycle;
        @(negedge clk);
        chk("t1_c1_setup", {psel, penable, pwrite}, 3'b101);
        chk("t1_c1_state", dbg_state, 1);
        chk("t1_c1_paddr", paddr, 32'h4);
        chk("t1_c1_pwdata", pwdata, 32'hDEADBEEF);
        chk("t1_c1_pstrb", pstrb, 4'hF);
        next_cycle;
        @(negedge clk);
        chk("t1_c2_access", {psel, penable}, 2'b11);
        chk("t1_c2_state", dbg_state, 2);
        chk("t1_c2_done", {done, err}, 3'b010);
        next_cycle;
        req = 2'b00;
        @(negedge clk);
        chk("t1_c3_idle", {psel, penable, paddr}, 0);

        // Both requesting from reset: six alternating back-to-back transfers
        next_cycle;
        do_reset;
        wr0 = 1'b1; wr1 = 1'b1; addr0 = 32'h10; addr1 = 32'h20;
        wdata0 = 32'h1111; wdata1 = 32'h2222; rd_val = '0; wait_n = 0;
        repeat (3) begin
            push_exp(2'b01, '0, 1'b0);
            push_exp(2'b10, '0, 1'b0);
        end
        req = 2'b11;
        for (int c = 0; c <= 13; c++) begin
            if (c > 0) next_cycle;
            if (c == 11) req[0] = 1'b0;
            if (c == 13) req[1] = 1'b0;
            @(negedge clk);
            chk("t2_psel", psel, (c >= 1 && c <= 12));
            chk("t2_penable", penable, (c >= 2 && c <= 12 && c % 2 == 0));
            if (c >= 1 && c <= 12 && c % 2 == 1)
                chk("t2_paddr", paddr, (((c - 1) / 2) % 2 == 1) ? 32'h20 : 32'h10);
            if (c >= 2 && c <= 12 && c % 2 == 0)
                chk("t2_ptrnsfr", ptrnsfr, (c <= 10));
        end

        // Read from requester 1 with three wait states
        next_cycle;
        wr1 = 1'b0; addr1 = 32'h2; rd_val = 32'h12345678; wait_n = 3;
        push_exp(2'b10, 32'h12345678, 1'b0);
        req = 2'b10;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) next_cycle;
            if (c == 6) req = 2'b00;
            @(negedge clk);
            if (c >= 1 && c <= 5) begin
                chk("t3_paddr", paddr, 32'h2);
                chk("t3_psel_rd", {psel, pwrite}, 2'b10);
            end
            if (c >= 2 && c <= 4) chk("t3_wait_done", done, 2'b00);
            if (c == 5) begin
                chk("t3_done", done, 2'b10);
                chk("t3_rdata", rdata, 32'h12345678);
            end
            if (c == 6) chk("t3_idle", psel, 0);
        end

        // Slave error
        next_cycle;
        wr0 = 1'b1; addr0 = 32'h8; rd_val = 32'h55; wait_n = 0; slv_err = 1'b1;
        push_exp(2'b01, 32'h55, 1'b1);
        req = 2'b01;
        repeat (2) next_cycle;
        @(negedge clk);
        chk("t4_err", {done, err}, 3'b011);
        next_cycle;
        req = 2'b00; slv_err = 1'b0;

        // Tie after requester 0 was granted last: requester 1 wins
        next_cycle;
        wr1 = 1'b1; addr1 = 32'h30; addr0 = 32'h40; rd_val = '0;
        push_exp(2'b10, '0, 1'b0);
        push_exp(2'b01, '0, 1'b0);
        req = 2'b11;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) next_cycle;
            if (c == 3) req[1] = 1'b0;
            if (c == 5) req[0] = 1'b0;
            @(negedge clk);
            if (c == 1) chk("t6_first_paddr", paddr, 32'h30);
            if (c == 2) chk("t6_ptrnsfr_hi", ptrnsfr, 1);
            if (c == 3) chk("t6_b2b_setup", {psel, penable, paddr}, {2'b10, 32'h40});
            if (c == 4) chk("t6_ptrnsfr_lo", ptrnsfr, 0);
            if (c == 5) chk("t6_idle", psel, 0);
        end

        // Owner drops req mid-transfer; completion still pulses
        next_cycle;
        addr0 = 32'h44; rd_val = 32'h77; wait_n = 2;
        push_exp(2'b01, 32'h77, 1'b0);
        req = 2'b01;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) next_cycle;
            if (c == 2) req = 2'b00;
            @(negedge clk);
            if (c == 4) chk("t7_done", done, 2'b01);
            if (c == 5) chk("t7_idle", psel, 0);
        end

        // Reset during ACCESS aborts without done
        next_cycle;
        wait_n = 10;
        req = 2'b01;
        repeat (2) next_cycle;
        @(negedge clk);
        chk("t5_in_access", {psel, penable}, 2'b11);
        next_cycle;
        rst = 1'b1;
        next_cycle;
        req = 2'b00;
        @(negedge clk);
        chk("t5_rst_ctrl", {psel, penable, pwrite, ptrnsfr, done, err}, 0);
        chk("t5_rst_paddr", paddr, 0);
        chk("t5_rst_pwdata", pwdata, 0);
        next_cycle;
        rst = 1'b0;
        repeat (2) next_cycle;
        @(negedge clk);
        chk("t5_after_idle", {psel, done}, 0);

`ifdef APB_ARB_TIMEOUT_EN
        // Watchdog: slave never answers
        next_cycle;
        begin
            int acc_seen;
            bit got_done;
            acc_seen = 0;
            got_done = 1'b0;
            wait_n = 1000; rd_val = 32'h99;
            push_exp(2'b01, '0, 1'b1);
            req = 2'b01;
            for (int c = 0; c < 40 && !got_done; c++) begin
                if (c > 0) next_cycle;
                @(negedge clk);
                if (psel && penable) acc_seen++;
                if (done !== 2'b00) got_done = 1'b1;
            end
            chk("to_done_seen", got_done, 1);
            chk("to_access_cycles", acc_seen, 16);
            next_cycle;
            req = 2'b00;
            next_cycle;
        end
`endif

        repeat (2) next_cycle;
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
